// File: rtl/mul_pkg.sv
// Shared constants for the multiply issue path: FSM encodings, lane count, round-robin pick.
// No timing of its own; used by the arbiter and its datapath.
package mul_pkg;

  localparam int NUM_LANES = 2;
  localparam int ALU_ISMUL = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Lane to grant: the only requester, or the one that did not win last time.
  function automatic logic rr_pick(input logic [NUM_LANES-1:0] valid, input logic last);
    rr_pick = (&valid) ? ~last : valid[1];
  endfunction

endpackage

// File: rtl/mul_iter_dp.sv
// Shift-add multiply datapath: load latches operands, each step retires one multiplier bit.
// DATA_W steps per product; no backpressure, the caller only steps while busy.
module mul_iter_dp #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] acc,
  output logic              last
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [CNT_W-1:0]  count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc   <= '0;
      count <= CNT_W'(DATA_W - 1);
    end else if (step) begin
      // Sum wraps at DATA_W bits, which is exactly the truncated product.
      if (b_q[0]) acc <= acc + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/mul_issue_arbiter.sv
// Round-robin shares one iterative multiplier between two issue lanes; result held until rsp_ready.
// Response seen DATA_W+1 edges after accept; no new grant while busy or while a branch flush is asserted.
module mul_issue_arbiter
  import mul_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           is_branch_takenin,
  input  logic [NUM_LANES-1:0]           req_valid,
  output logic [NUM_LANES-1:0]           req_ready,
  input  logic [NUM_LANES*DATA_W-1:0]    req_op1,
  input  logic [NUM_LANES*DATA_W-1:0]    req_op2,
  input  logic [NUM_LANES*INSTR_W-1:0]   req_instr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_lane,
  output logic [DATA_W-1:0]              rsp_result,
  output logic [INSTR_W-1:0]             rsp_instr,
  output logic                           busy
);

  state_t             state_q;
  logic               last_grant;
  logic               lane_q;
  logic [INSTR_W-1:0] instr_q;

  logic               grant;
  logic               idle_ok;
  logic               accept;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  acc;
  logic               last;

  assign grant   = rr_pick(req_valid, last_grant);
  assign idle_ok = (state_q == S_IDLE) && reset && !is_branch_takenin;
  assign req_ready = idle_ok ? ((grant ? 2'b10 : 2'b01) & req_valid) : 2'b00;
  assign accept  = |(req_valid & req_ready);

  assign op_a = grant ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
  assign op_b = grant ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];

  mul_iter_dp #(.DATA_W(DATA_W)) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (state_q == S_BUSY),
    .op_a  (op_a),
    .op_b  (op_b),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_grant <= 1'b1;
      lane_q     <= 1'b0;
      instr_q    <= '0;
    end else if (is_branch_takenin) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_q    <= S_BUSY;
          last_grant <= grant;
          lane_q     <= grant;
          instr_q    <= grant ? req_instr[2*INSTR_W-1:INSTR_W] : req_instr[INSTR_W-1:0];
        end
        S_BUSY: if (last) state_q <= S_DONE;
        S_DONE: if (rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are masked outside DONE so a partial accumulator never leaks out.
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_result = rsp_valid ? acc : '0;
  assign rsp_instr  = rsp_valid ? instr_q : '0;
  assign rsp_lane   = rsp_valid & lane_q;
  assign busy       = (state_q != S_IDLE);

endmodule
